// File: rtl/sync_ram_bytewe.sv
// rtl/sync_ram_bytewe.sv - single-port byte-write RAM with valid/ready access and hardware clear sequencer
// Optional per-lane even parity storage and checking: define SYNC_RAM_PARITY_EN.
module sync_ram_bytewe #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int BYTE_WIDTH = 8,
  parameter int READ_MODE  = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_start,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_data,
`ifdef SYNC_RAM_PARITY_EN
  input  logic                             perr_inject,
  output logic                             parity_err,
`endif
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   rd_data_d;

  assign busy      = reset || (state_q == CLEAR);
  assign req_ready = !reset && (state_q == IDLE) && !clear_start;
  assign accept    = req_valid && req_ready;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    old_word    = mem[req_addr];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      if (req_be[i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    // Only a write in new-data mode returns the merged word; everything else returns storage as it was.
    rd_data_d = (req_we && READ_MODE == 0) ? merged_word : old_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_addr_q] <= INIT_VALUE;
      end else if (accept && req_we) begin
        mem[req_addr] <= merged_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= accept;
      if (accept) rd_data_q <= rd_data_d;
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_WIDTH{1'b1}}) state_q <= IDLE;
        end
        IDLE: begin
          if (clear_start) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] init_par;
  logic [NB-1:0] old_par;
  logic [NB-1:0] merged_par;
  logic [NB-1:0] ret_par;
  logic [NB-1:0] ret_calc;
  logic          perr_d;
  logic          parity_err_q;

  always_comb begin
    old_par    = par_mem[req_addr];
    merged_par = old_par;
    init_par   = '0;
    ret_calc   = '0;
    for (int i = 0; i < NB; i++) begin
      init_par[i] = ^INIT_VALUE[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (req_be[i]) merged_par[i] = (^req_data[i*BYTE_WIDTH +: BYTE_WIDTH]) ^ perr_inject;
      ret_calc[i] = ^rd_data_d[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    ret_par = (req_we && READ_MODE == 0) ? merged_par : old_par;
    perr_d  = |(ret_calc ^ ret_par);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        par_mem[clr_addr_q] <= init_par;
      end else if (accept && req_we) begin
        par_mem[req_addr] <= merged_par;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) parity_err_q <= 1'b0;
    else       parity_err_q <= accept && perr_d;
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sync_ram_bytewe.sv
// tb/tb_sync_ram_bytewe.sv - scoreboard testbench for sync_ram_bytewe
module tb_sync_ram_bytewe;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int BW = 8;
  localparam int NB = 2;
  localparam int RM = 0;
  localparam logic [15:0] INIT = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_start = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [NB-1:0] req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          perr_inject = 1'b0;
  logic          parity_err;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;

  sync_ram_bytewe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .READ_MODE(RM), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk), .reset(reset), .clear_start(clear_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_data(req_data),
`ifdef SYNC_RAM_PARITY_EN
    .perr_inject(perr_inject), .parity_err(parity_err),
`endif
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
  );

`ifndef SYNC_RAM_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int ready_bad = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {16'd0, rd_data}, {16'd0, e[15:0]});
`ifdef SYNC_RAM_PARITY_EN
          check("parity_err", {31'd0, parity_err}, {31'd0, e[16]});
`endif
        end
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] be, input logic [5:0] addr,
                        input logic [15:0] data, input logic [15:0] exp,
                        input logic pexp = 1'b0, input logic inj = 1'b0);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_data = data; perr_inject = inj;
    #1;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back({pexp, exp});
    @(posedge clk); #1;
    check("rd_valid_latency", {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0; perr_inject = 1'b0;
    @(posedge clk); #1;
    check("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (req_ready !== 1'b0) ready_bad++;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    logic [15:0] d;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_rd_data", {16'd0, rd_data}, 32'd0);
    reset = 1'b0;
    count_busy(c);
    check("clear_cycles", c, 64);
    check("ready_during_clear", ready_bad, 0);

    access(1'b0, 2'b00, 6'd0, 16'h0, INIT);
    access(1'b0, 2'b00, 6'd31, 16'h0, INIT);
    access(1'b0, 2'b00, 6'd63, 16'h0, INIT);
    idle();

    access(1'b1, 2'b11, 6'd5, 16'h1234, 16'h1234);
    access(1'b1, 2'b01, 6'd5, 16'hABCD, (RM != 0) ? 16'h1234 : 16'h12CD);
    access(1'b1, 2'b00, 6'd5, 16'h0000, 16'h12CD);
    access(1'b0, 2'b11, 6'd5, 16'hFFFF, 16'h12CD);
    idle();

    for (int i = 0; i < 8; i++) begin
      d = 16'h3C00 + 16'(i) * 16'h0101;
      access(1'b1, 2'b11, 6'(i), d, d);
      access(1'b0, 2'b00, 6'(i), 16'h0, d);
    end
    idle();

    access(1'b1, 2'b11, 6'd2, 16'hBEEF, 16'hBEEF);
    idle();
    clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd2;
    #1;
    check("clear_start_ready", {31'd0, req_ready}, 32'd0);
    check("clear_start_busy_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    clear_start = 1'b0; req_valid = 1'b0;
    ready_bad = 0;
    count_busy(c);
    check("reclear_cycles", c, 64);
    check("ready_during_reclear", ready_bad, 0);
    access(1'b0, 2'b00, 6'd2, 16'h0, INIT);
    idle();

    access(1'b1, 2'b11, 6'd40, 16'h5555, 16'h5555);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midclear_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midclear_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    count_busy(c);
    check("restart_clear_cycles", c, 64);
    access(1'b0, 2'b00, 6'd40, 16'h0, INIT);
    idle();

`ifdef SYNC_RAM_PARITY_EN
    access(1'b1, 2'b11, 6'd9, 16'h00FF, (RM != 0) ? INIT : 16'h00FF, (RM != 0) ? 1'b0 : 1'b1, 1'b1);
    access(1'b0, 2'b00, 6'd9, 16'h0, 16'h00FF, 1'b1);
    access(1'b1, 2'b11, 6'd9, 16'h00FF, 16'h00FF, (RM != 0) ? 1'b1 : 1'b0, 1'b0);
    access(1'b0, 2'b00, 6'd9, 16'h0, 16'h00FF, 1'b0);
    idle();
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
